// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the CPU control sequencer.
//   - Opcode values carried in IR[31:27]
//   - ALU operation codes driven on the OP bus
//   - Sequencer state encoding and instruction class encoding
//   - IR field bit positions
//   - Helpers mapping an opcode to its class and to its ALU operation
package cpu_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // ALU operation select values
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] ALU_MUL  = 5'b01000;
  localparam logic [4:0] ALU_NEG  = 5'b01001;
  localparam logic [4:0] ALU_NOT  = 5'b01010;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU3 = 3'd1,
    CLS_MD   = 3'd2,
    CLS_UN   = 3'd3,
    CLS_HALT = 3'd4
  } iclass_e;

  // Unknown opcodes fall into the NOP class so they retire after fetch.
  function automatic iclass_e decode_class(input logic [4:0] opc);
    iclass_e cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: cls = CLS_ALU3;
      OPC_MUL, OPC_DIV:                  cls = CLS_MD;
      OPC_NEG, OPC_NOT:                  cls = CLS_UN;
      OPC_HALT:                          cls = CLS_HALT;
      default:                           cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  // ALU operation for an opcode; opcode and ALU codes differ for MD/UN.
  function automatic logic [4:0] alu_op(input logic [4:0] opc);
    logic [4:0] op;
    case (opc)
      OPC_ADD: op = ALU_ADD;
      OPC_SUB: op = ALU_SUB;
      OPC_AND: op = ALU_AND;
      OPC_OR:  op = ALU_OR;
      OPC_MUL: op = ALU_MUL;
      OPC_DIV: op = ALU_DIV;
      OPC_NEG: op = ALU_NEG;
      OPC_NOT: op = ALU_NOT;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// reg_select_decode: 4-bit register number to one-hot select.
//   en_i      in  1          drive a select this cycle
//   sel_i     in  4          register number
//   onehot_o  out REG_COUNT  bit n high iff en_i and sel_i == n
module reg_select_decode #(
  parameter int REG_COUNT = 16
) (
  input  logic                 en_i,
  input  logic [3:0]           sel_i,
  output logic [REG_COUNT-1:0] onehot_o
);

  // One-hot decode; numbers beyond REG_COUNT select nothing.
  always_comb begin
    onehot_o = '0;
    for (int n = 0; n < REG_COUNT; n++) begin
      if (en_i && ({28'd0, sel_i} == n)) begin
        onehot_o[n] = 1'b1;
      end else begin
        onehot_o[n] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore control sequencer for the CPU datapath.
//   Clock, Clear(async active-low), Run  in   timing / start permission
//   IR[31:0]                             in   instruction from datapath
//   Rin, Rout [REG_COUNT]                out  one-hot register load/drive
//   PCout PCin MARin MDRin MDRout IRin Yin
//   ZHighin ZLowin ZHighout ZLowout HIin LOin
//   Read IncPC                           out  datapath strobes
//   OP[4:0]                              out  ALU operation (0 outside ALU step)
//   Halted                               out  high while parked in HALT
// Each instruction fetches in T0-T2 and executes in T3..T6 depending on
// its class. Outputs decode from state and IR only.
module control_unit
  import cpu_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 Run,
  input  logic [31:0]          IR,
  output logic [REG_COUNT-1:0] Rin,
  output logic [REG_COUNT-1:0] Rout,
  output logic                 PCout,
  output logic                 PCin,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 ZHighin,
  output logic                 ZLowin,
  output logic                 ZHighout,
  output logic                 ZLowout,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 Read,
  output logic                 IncPC,
  output logic [4:0]           OP,
  output logic                 Halted
);

  state_e     state_q, state_d;
  iclass_e    cls_s;
  logic [4:0] opc_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       rin_en_s, rout_en_s;
  logic [3:0] rin_sel_s, rout_sel_s;
  state_e     eoi_s;

  assign opc_s = IR[OPC_MSB:OPC_LSB];
  assign ra_s  = IR[RA_MSB:RA_LSB];
  assign rb_s  = IR[RB_MSB:RB_LSB];
  assign rc_s  = IR[RC_MSB:RC_LSB];
  assign cls_s = decode_class(opc_s);

  // Run is only consulted here, at the instruction boundary.
  assign eoi_s = Run ? ST_T0 : ST_IDLE;

  // State register; Clear forces IDLE at once, which zeroes every output.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = Run ? ST_T0 : ST_IDLE;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        case (cls_s)
          CLS_HALT: state_d = ST_HALT;
          CLS_NOP:  state_d = eoi_s;
          default:  state_d = ST_T3;
        endcase
      end
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = (cls_s == CLS_UN) ? eoi_s : ST_T5;
      ST_T5:   state_d = (cls_s == CLS_MD) ? ST_T6 : eoi_s;
      ST_T6:   state_d = eoi_s;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode; Rin and Rout are never enabled in the same state.
  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZHighin    = 1'b0;
    ZLowin     = 1'b0;
    ZHighout   = 1'b0;
    ZLowout    = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Read       = 1'b0;
    IncPC      = 1'b0;
    OP         = ALU_NONE;
    Halted     = 1'b0;
    rin_en_s   = 1'b0;
    rin_sel_s  = 4'd0;
    rout_en_s  = 1'b0;
    rout_sel_s = 4'd0;
    case (state_q)
      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        ZLowin  = 1'b1;
        ZHighin = 1'b1;
      end
      ST_T1: begin
        ZLowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (cls_s)
          CLS_ALU3: begin
            rout_en_s  = 1'b1;
            rout_sel_s = rb_s;
            Yin        = 1'b1;
          end
          CLS_MD: begin
            rout_en_s  = 1'b1;
            rout_sel_s = ra_s;
            Yin        = 1'b1;
          end
          CLS_UN: begin
            rout_en_s  = 1'b1;
            rout_sel_s = rb_s;
            OP         = alu_op(opc_s);
            ZLowin     = 1'b1;
            ZHighin    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls_s)
          CLS_ALU3: begin
            rout_en_s  = 1'b1;
            rout_sel_s = rc_s;
            OP         = alu_op(opc_s);
            ZLowin     = 1'b1;
            ZHighin    = 1'b1;
          end
          CLS_MD: begin
            rout_en_s  = 1'b1;
            rout_sel_s = rb_s;
            OP         = alu_op(opc_s);
            ZLowin     = 1'b1;
            ZHighin    = 1'b1;
          end
          CLS_UN: begin
            ZLowout   = 1'b1;
            rin_en_s  = 1'b1;
            rin_sel_s = ra_s;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls_s)
          CLS_ALU3: begin
            ZLowout   = 1'b1;
            rin_en_s  = 1'b1;
            rin_sel_s = ra_s;
          end
          CLS_MD: begin
            ZLowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (cls_s == CLS_MD) begin
          ZHighout = 1'b1;
          HIin     = 1'b1;
        end else begin
          ZHighout = 1'b0;
          HIin     = 1'b0;
        end
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  reg_select_decode #(.REG_COUNT(REG_COUNT)) u_rin_dec (
    .en_i     (rin_en_s),
    .sel_i    (rin_sel_s),
    .onehot_o (Rin)
  );

  reg_select_decode #(.REG_COUNT(REG_COUNT)) u_rout_dec (
    .en_i     (rout_en_s),
    .sel_i    (rout_sel_s),
    .onehot_o (Rout)
  );

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control sequencer for the CPU datapath. It drives the per-cycle control strobes (register in/out selects, PC/MAR/MDR/IR/Y/Z/HI/LO enables, memory Read, IncPC, ALU OP) that the directed benches currently apply by hand. Each instruction runs fetch steps T0–T2, then opcode-dependent execute steps T3–T6. The block sits beside `datapath` and reads the IR contents back from it.

## Interface
Parameters:
- REG_COUNT, 16, number of general registers; sets the width of the one-hot Rin/Rout buses.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  reset, asynchronous and active-low.
- Run  in  1  level; permits the start of a new instruction.
- IR  in  32  instruction register contents from the datapath.
- Rin / Rout  out  REG_COUNT  one-hot register load / drive selects.
- PCout, PCin, MARin, MDRin, MDRout, IRin, Yin  out  1  datapath strobes.
- ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin  out  1  datapath strobes.
- Read, IncPC  out  1  memory read and PC increment.
- OP  out  5  ALU operation select.
- Halted  out  1  high while in HALT.

## Operation
- IR fields:
  - opc = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
- Rin/Rout bit n is 1 iff the selected field equals n.
- Instruction classes:
  - ALU3 (add 00011, sub 00100, and 00101, or 00110): `op Ra,Rb,Rc`.
  - MD (mul 01111, div 10000): `op Ra,Rb`.
  - UN (neg 10001, not 10010): `op Ra,Rb`.
  - NOP 11010.
  - HALT 11011.
  - Any other opc executes as NOP.
- ALU OP encoding: ADD 00011, SUB 00100, AND 00101, OR 00110, DIV 00111, MUL 01000, NEG 01001, NOT 01010. OP is 00000 in every state except the ALU step.
- States: IDLE, T0–T6, HALT. Outputs are decoded from state and IR only (Moore); every strobe is held high for the whole cycle.
- Per-state strobes:
  - IDLE: all outputs 0.
  - T0: PCout, MARin, IncPC, ZLowin, ZHighin.
  - T1: ZLowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3:
    - ALU3: Rout[Rb], Yin.
    - MD: Rout[Ra], Yin.
    - UN: Rout[Rb], OP, ZLowin, ZHighin.
  - T4:
    - ALU3: Rout[Rc], OP, ZLowin, ZHighin.
    - MD: Rout[Rb], OP, ZLowin, ZHighin.
    - UN: ZLowout, Rin[Ra].
  - T5:
    - ALU3: ZLowout, Rin[Ra].
    - MD: ZLowout, LOin.
  - T6 (MD only): ZHighout, HIin.
- Transitions:
  - IDLE→T0 when Run=1.
  - T0→T1→T2 unconditionally.
  - T2→HALT if opc=HALT.
  - T2→end-of-instruction if NOP or illegal.
  - The last execute step goes to end-of-instruction: T5 for ALU3, T6 for MD, T4 for UN.
  - End-of-instruction goes to T0 if Run=1, otherwise IDLE.
- Run is sampled only at the instruction boundary. Deasserting Run mid-instruction lets the current instruction finish.
- HALT holds, with Halted=1, until Clear.
- Writes to R0 are permitted (no hardwired zero).

## Timing
- Clear low: state→IDLE immediately, every output 0 asynchronously, Halted=0.
- First edge after Clear deasserts with Run=1: enter T0.
- IR is captured by the datapath at the end of T2; opcode decode is valid from T3 and is also used at the T2→next transition.
- Cycles per instruction, T0 through last step:
  - NOP: 3.
  - UN: 5.
  - ALU3: 6.
  - MD: 7.
  - HALT: 3, then parks.
- Back-to-back: the next T0 directly follows the last step, with no bubble.
- Clear during any T-state aborts the instruction. No partial write occurs beyond strobes already clocked.

## Structure
- Package `cpu_pkg`: opcode constants, ALU OP constants, state enum, IR field bit positions.
- Sub-module `reg_select_decode`: 4-to-REG_COUNT one-hot decoder, instantiated for the Rin and Rout paths. Within one state, Rin and Rout are never nonzero in the same cycle.

## Test plan
- DIV, IR=0x83380000, Run=1 →
  - T3: Rout=0x0040, Yin.
  - T4: Rout=0x0080, OP=00111, ZLowin, ZHighin.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin.
  - Next cycle is T0.
- ADD, IR=0x18A18000 →
  - T3: Rout=0x0010.
  - T4: Rout=0x0008, OP=00011.
  - T5: Rin=0x0002.
  - 6-cycle instruction.
- NOP 0xD0000000 then an illegal opcode 0xF8000000 → each takes 3 cycles, no Rin/Rout, OP=0.
- HALT 0xD8000000 → Halted=1 from the cycle after T2, outputs otherwise 0, held for 20 cycles; Clear low then high with Run=1 → T0.
- Clear pulsed low mid-T4 of an ADD → all strobes 0 within the same cycle, state IDLE.
- Run dropped during T3 of a MUL → MUL completes through T6, then IDLE. Run re-raised → T0 on the next edge.
